fir_output_capture: RTL and testbench

- Synthesizable response-side companion to the 4-tap FIR (fir_4tap). It sits on the filter output Yout and captures a window of output samples into an internal buffer once a magnitude trigger fires.
- It tracks peak max/min over the window, then streams the captured samples out over a valid/ready read port.
- It closes the loop opposite the sample driver: the driver feeds Xin, this block reads Yout back.

---
 rtl/fir_output_capture.sv | 155 +++++++++++++++
 tb/tb_fir_output_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_capture.sv
// fir_output_capture: captures a DEPTH-sample window of FIR output after a
// magnitude trigger, tracks the window's signed peaks, then streams it out.
// Ports:
//   Clk, Rst               clock, synchronous active-high reset
//   Yin                    signed filter output sample, one per cycle
//   Arm, Thresh            arm request and |Yin| trigger threshold
//   Abort                  return to IDLE from any busy state, no Done
//   Busy                   high in ARMED, CAPTURE and DUMP
//   Rd_valid/ready/data    valid/ready read port over the captured window
//   Rd_index, Rd_last      window position of Rd_data, final-beat flag
//   Done                   one-cycle pulse after the last beat is accepted
//   Peak_max, Peak_min     signed extremes of the current/last window
module fir_output_capture #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic signed [DW-1:0] Yin,
    input  logic                 Arm,
    input  logic                 Abort,
    input  logic        [DW-1:0] Thresh,
    output logic                 Busy,
    output logic                 Rd_valid,
    input  logic                 Rd_ready,
    output logic signed [DW-1:0] Rd_data,
    output logic        [AW-1:0] Rd_index,
    output logic                 Rd_last,
    output logic                 Done,
    output logic signed [DW-1:0] Peak_max,
    output logic signed [DW-1:0] Peak_min
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DUMP
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t                state_q, state_d;
    logic         [DW-1:0] thresh_q, thresh_d;
    logic         [AW-1:0] wptr_q, wptr_d;
    logic         [AW-1:0] rptr_q, rptr_d;
    logic signed  [DW-1:0] pmax_q, pmax_d;
    logic signed  [DW-1:0] pmin_q, pmin_d;
    logic                  done_q, done_d;
    logic signed  [DW-1:0] mem_q [DEPTH];
    logic signed  [DW-1:0] mem_d [DEPTH];

    // One extra bit so |-2^(DW-1)| = 2^(DW-1) is representable.
    logic [DW:0] yin_ext;
    logic [DW:0] yin_mag;
    logic        trig;

    always_comb begin
        yin_ext = {Yin[DW-1], Yin};
        yin_mag = Yin[DW-1] ? (~yin_ext + (DW+1)'(1)) : yin_ext;
        trig    = (yin_mag >= {1'b0, thresh_q});
    end

    always_comb begin
        state_d  = state_q;
        thresh_d = thresh_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        pmax_d   = pmax_q;
        pmin_d   = pmin_q;
        done_d   = 1'b0;
        mem_d    = mem_q;

        if (state_q != IDLE && Abort) begin
            // Peaks deliberately keep their partial values.
            state_d = IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Arm) begin
                        thresh_d = Thresh;
                        state_d  = ARMED;
                    end
                end
                ARMED: begin
                    if (trig) begin
                        mem_d[0] = Yin;
                        pmax_d   = Yin;
                        pmin_d   = Yin;
                        wptr_d   = AW'(1);
                        state_d  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    mem_d[wptr_q] = Yin;
                    if (Yin > pmax_q) pmax_d = Yin;
                    if (Yin < pmin_q) pmin_d = Yin;
                    // Natural wrap of the AW-bit pointer returns it to 0.
                    wptr_d = wptr_q + AW'(1);
                    if (wptr_q == LAST_IDX) state_d = DUMP;
                end
                DUMP: begin
                    if (Rd_ready) begin
                        if (rptr_q == LAST_IDX) begin
                            rptr_d  = '0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            rptr_d = rptr_q + AW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            thresh_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            pmax_q   <= '0;
            pmin_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            thresh_q <= thresh_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            pmax_q   <= pmax_d;
            pmin_q   <= pmin_d;
            done_q   <= done_d;
        end
    end

    // Sample storage is not reset; only writes are suppressed under Rst.
    always_ff @(posedge Clk) begin
        if (!Rst) mem_q <= mem_d;
    end

    assign Busy     = (state_q != IDLE);
    assign Rd_valid = (state_q == DUMP);
    assign Rd_data  = mem_q[rptr_q];
    assign Rd_index = rptr_q;
    assign Rd_last  = Rd_valid && (rptr_q == LAST_IDX);
    assign Done     = done_q;
    assign Peak_max = pmax_q;
    assign Peak_min = pmin_q;

endmodule

// File: tb/tb_fir_output_capture.sv
// Bench for fir_output_capture: directed steps, with a behavioural capture
// model feeding a scoreboard queue that is drained against the read port.
module tb_fir_output_capture;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic signed [DW-1:0] Yin;
    logic                 Arm;
    logic                 Abort;
    logic        [DW-1:0] Thresh;
    logic                 Busy;
    logic                 Rd_valid;
    logic                 Rd_ready;
    logic signed [DW-1:0] Rd_data;
    logic        [AW-1:0] Rd_index;
    logic                 Rd_last;
    logic                 Done;
    logic signed [DW-1:0] Peak_max;
    logic signed [DW-1:0] Peak_min;

    always #5 Clk = ~Clk;

    fir_output_capture #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Yin      (Yin),
        .Arm      (Arm),
        .Abort    (Abort),
        .Thresh   (Thresh),
        .Busy     (Busy),
        .Rd_valid (Rd_valid),
        .Rd_ready (Rd_ready),
        .Rd_data  (Rd_data),
        .Rd_index (Rd_index),
        .Rd_last  (Rd_last),
        .Done     (Done),
        .Peak_max (Peak_max),
        .Peak_min (Peak_min)
    );

    typedef enum {M_IDLE, M_ARMED, M_CAP, M_DUMP} mst_t;

    int                   checks = 0;
    int                   errors = 0;
    logic signed [DW-1:0] sb [$];
    mst_t                 mst = M_IDLE;
    logic        [DW-1:0] mthr = '0;
    logic signed [DW-1:0] mmax = '0;
    logic signed [DW-1:0] mmin = '0;
    int                   mcnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_clear();
        mst = M_IDLE;
        sb.delete();
    endtask

    task automatic arm(input logic [DW-1:0] th, input logic with_abort);
        Arm    = 1'b1;
        Abort  = with_abort;
        Thresh = th;
        step();
        Arm   = 1'b0;
        Abort = 1'b0;
        mthr  = th;
        mst   = M_ARMED;
        chk("arm_busy", 32'(Busy), 32'(1));
        chk("arm_no_valid", 32'(Rd_valid), 32'(0));
    endtask

    task automatic drive(input logic signed [DW-1:0] y);
        longint v;
        longint mag;
        Yin = y;
        v   = longint'(y);
        mag = (v < 0) ? -v : v;
        if (mst == M_ARMED && mag >= longint'(mthr)) begin
            mst  = M_CAP;
            sb.push_back(y);
            mmax = y;
            mmin = y;
            mcnt = 1;
        end else if (mst == M_CAP) begin
            sb.push_back(y);
            if (y > mmax) mmax = y;
            if (y < mmin) mmin = y;
            mcnt++;
            if (mcnt == DEPTH) mst = M_DUMP;
        end
        step();
        chk("busy", 32'(Busy), 32'(mst != M_IDLE));
        chk("rd_valid", 32'(Rd_valid), 32'(mst == M_DUMP));
    endtask

    task automatic drain(input bit stall, input bit arm_last);
        int                   beat = 0;
        bit                   r;
        bit                   fin = 1'b0;
        logic signed [DW-1:0] exp;
        for (int i = 0; i < 200 && !fin; i++) begin
            r        = stall ? (i % 4 == 0 || i % 4 == 3) : 1'b1;
            Rd_ready = r;
            Yin      = $urandom;
            exp      = (sb.size() > 0) ? sb[0] : '0;
            chk("dump_valid", 32'(Rd_valid), 32'(1));
            chk("rd_data", Rd_data, exp);
            chk("rd_index", 32'(Rd_index), 32'(beat));
            chk("rd_last", 32'(Rd_last), 32'(beat == DEPTH - 1));
            if (r) begin
                if (sb.size() > 0) void'(sb.pop_front());
                if (beat == DEPTH - 1) begin
                    Arm    = arm_last;
                    Thresh = '0;
                    fin    = 1'b1;
                end
                beat++;
            end
            step();
            Arm = 1'b0;
        end
        Rd_ready = 1'b0;
        chk("drain_in_time", 32'(fin), 32'(1));
        chk("beats", 32'(beat), 32'(DEPTH));
        chk("done_pulse", 32'(Done), 32'(1));
        chk("valid_drop", 32'(Rd_valid), 32'(0));
        chk("busy_idle", 32'(Busy), 32'(0));
        mst = M_IDLE;
        step();
        chk("done_single", 32'(Done), 32'(0));
        chk("no_restart", 32'(Busy), 32'(0));
        chk("peak_max", Peak_max, mmax);
        chk("peak_min", Peak_min, mmin);
    endtask

    initial begin
        Rst      = 1'b1;
        Yin      = '0;
        Arm      = 1'b0;
        Abort    = 1'b0;
        Thresh   = '0;
        Rd_ready = 1'b0;
        step();
        step();
        Rst = 1'b0;
        chk("rst_busy", 32'(Busy), 32'(0));
        chk("rst_valid", 32'(Rd_valid), 32'(0));
        chk("rst_done", 32'(Done), 32'(0));
        chk("rst_last", 32'(Rd_last), 32'(0));
        chk("rst_index", 32'(Rd_index), 32'(0));
        chk("rst_pmax", Peak_max, 32'(0));
        chk("rst_pmin", Peak_min, 32'(0));

        // Trigger on -100 with threshold 100; read out with stalls.
        arm(32'd100, 1'b0);
        drive(-18);
        drive(-44);
        drive(99);
        drive(-100);
        drive(84);
        for (int i = 0; i < DEPTH - 2; i++) drive(i * 13 - 90);
        chk("beat0_data", Rd_data, -100);
        drain(1'b1, 1'b0);

        // Arm+Abort in IDLE arms; zero threshold; ramp 1..16;
        // Arm on the final beat must be ignored.
        arm(32'd0, 1'b1);
        for (int k = 1; k <= DEPTH; k++) drive(k);
        drain(1'b0, 1'b1);
        chk("ramp_pmax", Peak_max, 32'd16);
        chk("ramp_pmin", Peak_min, 32'd1);

        // Magnitude boundary: 2^31-1 misses, -2^31 hits 2^31.
        arm(32'h8000_0000, 1'b0);
        drive(32'sh7fff_ffff);
        drive(-5);
        chk("no_trig_busy", 32'(Busy), 32'(1));
        drive(32'sh8000_0000);
        for (int i = 1; i < DEPTH; i++) drive(i * 1000 - 7000);
        chk("minneg_pmin", Peak_min, 32'h8000_0000);
        drain(1'b0, 1'b0);

        // Abort during CAPTURE with wptr at 5.
        arm(32'd0, 1'b0);
        drive(10);
        drive(20);
        drive(30);
        drive(40);
        drive(50);
        Abort = 1'b1;
        Yin   = 99;
        step();
        Abort = 1'b0;
        model_clear();
        chk("abort_busy", 32'(Busy), 32'(0));
        chk("abort_valid", 32'(Rd_valid), 32'(0));
        chk("abort_done", 32'(Done), 32'(0));
        chk("abort_pmax", Peak_max, 32'd50);
        chk("abort_pmin", Peak_min, 32'd10);
        for (int i = 0; i < 20; i++) begin
            Yin = $urandom;
            step();
            chk("post_abort_valid", 32'(Rd_valid), 32'(0));
            chk("post_abort_done", 32'(Done), 32'(0));
        end

        // Reset in the middle of DUMP while stalled.
        arm(32'd0, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive(-i);
        Rd_ready = 1'b0;
        step();
        chk("stall_valid", 32'(Rd_valid), 32'(1));
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        model_clear();
        chk("mrst_busy", 32'(Busy), 32'(0));
        chk("mrst_valid", 32'(Rd_valid), 32'(0));
        chk("mrst_done", 32'(Done), 32'(0));
        chk("mrst_pmax", Peak_max, 32'd0);
        chk("mrst_pmin", Peak_min, 32'd0);
        arm(32'd50, 1'b0);
        drive(3);
        drive(-49);
        drive(60);
        for (int i = 1; i < DEPTH; i++) drive(i * 7 - 40);
        drain(1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
